// File: rtl/memory_arbiter.sv
// Two-port (data/instruction) arbiter in front of a single-ported synchronous memory.
// One access in flight: IDLE grants, ACCESS drives the memory, RESP returns done/rdata.
module memory_arbiter #(
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic        dDone,
  output logic [31:0] dRdata,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic        iDone,
  output logic [31:0] iRdata,
  output logic [31:0] memAddr,
  output logic        memWe,
  output logic        memRe,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        own_i_q, own_i_d;
  logic [31:0] drdata_q, drdata_d;
  logic [31:0] irdata_q, irdata_d;
  logic        grant_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      own_i_q  <= 1'b0;
      drdata_q <= 32'd0;
      irdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      own_i_q  <= own_i_d;
      drdata_q <= drdata_d;
      irdata_q <= irdata_d;
    end
  end

  // Instruction wins only when data is absent or has hit its contended streak limit.
  assign grant_i = iReq & (~dReq | (streak_q == STREAK_MAX));

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    own_i_d  = own_i_q;
    drdata_d = drdata_q;
    irdata_d = irdata_q;
    case (state_q)
      IDLE: begin
        if (dReq | iReq) begin
          own_i_d = grant_i;
          addr_d  = grant_i ? iAddr : dAddr;
          we_d    = grant_i ? 1'b0 : dWe;
          wdata_d = (grant_i | ~dWe) ? 32'd0 : dWdata;
          if (grant_i) begin
            streak_d = 4'd0;
          end else if (iReq && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (!we_q) begin
          if (own_i_q) irdata_d = memRdata;
          else         drdata_d = memRdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes are decoded from state so an asynchronous reset kills them at once.
  assign memAddr  = (state_q == ACCESS) ? addr_q : 32'd0;
  assign memRe    = (state_q == ACCESS) & ~we_q;
  assign memWe    = (state_q == ACCESS) & we_q;
  assign memWdata = ((state_q == ACCESS) & we_q) ? wdata_q : 32'd0;

  assign dDone = (state_q == RESP) & ~own_i_q;
  assign iDone = (state_q == RESP) & own_i_q;

  // Read data is forwarded straight from memory in RESP, then held by the port register.
  assign dRdata = ((state_q == RESP) & ~own_i_q & ~we_q) ? memRdata : drdata_q;
  assign iRdata = ((state_q == RESP) & own_i_q & ~we_q) ? memRdata : irdata_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of pending requests and memory contents.
module tb_memory_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dReq, dWe, iReq;
  logic [31:0] dAddr, dWdata, iAddr;
  logic        dDone, iDone, memWe, memRe, busy;
  logic [31:0] dRdata, iRdata, memAddr, memWdata;
  logic [31:0] memRdata = 32'd0;

  int tests = 0;
  int fails = 0;

  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  memory_arbiter #(.DATA_STREAK_MAX(MAX)) dut (
    .clk(clk), .reset(reset),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .dDone(dDone), .dRdata(dRdata),
    .iReq(iReq), .iAddr(iAddr), .iDone(iDone), .iRdata(iRdata),
    .memAddr(memAddr), .memWe(memWe), .memRe(memRe), .memWdata(memWdata),
    .memRdata(memRdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 32'd0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
  endfunction

  // Synchronous-read memory device
  always @(posedge clk) begin
    if (memWe) dev_mem[memAddr] = memWdata;
    if (memRe) memRdata <= dev_rd(memAddr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_mem(input string tag);
    chk({tag, "_memAddr"}, memAddr, 32'd0);
    chk({tag, "_memRe"}, 32'(memRe), 32'd0);
    chk({tag, "_memWe"}, 32'(memWe), 32'd0);
    chk({tag, "_memWdata"}, memWdata, 32'd0);
  endtask

  logic        dp, ip, dpwe, gi, we;
  logic [31:0] dpa, dpw, ipa, a, wd;
  logic [31:0] exp_drd, exp_ird;
  int          streak_m;
  int          dd, id;

  initial begin
    reset = 1'b1;
    dReq = 0; dWe = 0; dAddr = 0; dWdata = 0; iReq = 0; iAddr = 0;
    dev_mem[32'h10] = 32'h00500093; ref_mem[32'h10] = 32'h00500093;
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dDone", 32'(dDone), 0);
    chk("rst_iDone", 32'(iDone), 0);
    chk("rst_dRdata", dRdata, 0);
    chk("rst_iRdata", iRdata, 0);
    chk_idle_mem("rst");
    step(); step();
    reset = 1'b0;

    // Fetch only
    iReq = 1; iAddr = 32'h10;
    chk("f0_busy", 32'(busy), 0);
    step();
    chk("f1_memRe", 32'(memRe), 1);
    chk("f1_memAddr", memAddr, 32'h10);
    chk("f1_memWe", 32'(memWe), 0);
    step();
    chk("f2_iDone", 32'(iDone), 1);
    chk("f2_iRdata", iRdata, 32'h00500093);
    chk("f2_dDone", 32'(dDone), 0);
    chk_idle_mem("f2");
    iReq = 0;
    step();
    chk("f3_iDone", 32'(iDone), 0);
    chk("f3_iRdata_hold", iRdata, 32'h00500093);
    chk("f3_busy", 32'(busy), 0);

    // Data write then read
    dReq = 1; dWe = 1; dAddr = 32'h40; dWdata = 32'hDEADBEEF;
    step();
    chk("w1_memWe", 32'(memWe), 1);
    chk("w1_memRe", 32'(memRe), 0);
    chk("w1_memAddr", memAddr, 32'h40);
    chk("w1_memWdata", memWdata, 32'hDEADBEEF);
    ref_mem[32'h40] = 32'hDEADBEEF;
    step();
    chk("w2_dDone", 32'(dDone), 1);
    chk("w2_memWe", 32'(memWe), 0);
    chk("w2_dRdata_unchanged", dRdata, 32'd0);
    dReq = 0;
    step();
    dReq = 1; dWe = 0; dWdata = 32'd0;
    step();
    chk("r1_memRe", 32'(memRe), 1);
    chk("r1_memWdata", memWdata, 32'd0);
    step();
    chk("r2_dDone", 32'(dDone), 1);
    chk("r2_dRdata", dRdata, 32'hDEADBEEF);
    dReq = 0;
    step();
    chk("r3_dRdata_hold", dRdata, 32'hDEADBEEF);

    // Request dropped during ACCESS still completes
    dReq = 1; dWe = 0; dAddr = 32'h40;
    step();
    dReq = 0;
    step();
    chk("drop_dDone", 32'(dDone), 1);
    chk("drop_dRdata", dRdata, 32'hDEADBEEF);
    step();
    chk("drop_busy", 32'(busy), 0);
    chk("drop_dDone_end", 32'(dDone), 0);

    // Reset during the ACCESS cycle of a write
    dev_mem[32'h80] = 32'hA5A5A5A5; ref_mem[32'h80] = 32'hA5A5A5A5;
    dReq = 1; dWe = 1; dAddr = 32'h80; dWdata = 32'h12345678;
    step();
    chk("ra_memWe_pre", 32'(memWe), 1);
    reset = 1'b1;
    #1;
    chk("ra_memWe", 32'(memWe), 0);
    chk("ra_busy", 32'(busy), 0);
    chk("ra_dDone", 32'(dDone), 0);
    chk("ra_dRdata_clr", dRdata, 32'd0);
    dReq = 0; dWe = 0;
    step();
    chk("ra_dDone2", 32'(dDone), 0);
    step();
    reset = 1'b0;
    chk("ra_mem80", dev_rd(32'h80), 32'hA5A5A5A5);
    step();
    chk("ra_dDone3", 32'(dDone), 0);

    // Simultaneous first requests after reset
    dReq = 1; dWe = 0; dAddr = 32'h40; iReq = 1; iAddr = 32'h10;
    dd = -1; id = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("sim_both_done", 32'(dDone & iDone), 0);
      if (dDone && dd < 0) begin dd = c; dReq = 0; end
      if (iDone && id < 0) begin id = c; iReq = 0; end
    end
    chk("sim_dDone_cycle", 32'(dd), 2);
    chk("sim_iDone_gap", 32'(id - dd), 3);

    // Continuous contention
    dReq = 1; dWe = 0; dAddr = 32'h40; iReq = 1; iAddr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      step(); step();
      chk($sformatf("cont_grant%0d", k), {30'd0, dDone, iDone},
          ((k % 5) == 4) ? 32'd1 : 32'd2);
      step();
    end
    dReq = 0; iReq = 0;

    // Randomized traffic against the transaction model
    reset = 1'b1;
    step();
    reset = 1'b0;
    streak_m = 0; exp_drd = 0; exp_ird = 0;
    dp = 0; ip = 0; dpwe = 0; dpa = 0; dpw = 0; ipa = 0;
    for (int t = 0; t < 300; t++) begin
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; dpwe = 1'($urandom_range(0, 1));
        dpa = 32'h100 + 32'(4 * $urandom_range(0, 7)); dpw = $urandom;
      end
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1; ipa = 32'h100 + 32'(4 * $urandom_range(0, 7));
      end
      dReq = dp; dWe = dpwe; dAddr = dpa; dWdata = dpw; iReq = ip; iAddr = ipa;
      chk("rnd_idle_busy", 32'(busy), 0);
      chk("rnd_idle_done", {30'd0, dDone, iDone}, 0);
      chk("rnd_idle_dRdata", dRdata, exp_drd);
      chk("rnd_idle_iRdata", iRdata, exp_ird);
      chk_idle_mem("rnd_idle");
      if (!dp && !ip) begin
        step();
        continue;
      end
      gi = ip && (!dp || streak_m == MAX);
      if (gi) streak_m = 0;
      else if (ip && streak_m < MAX) streak_m++;
      a  = gi ? ipa : dpa;
      we = gi ? 1'b0 : dpwe;
      wd = dpw;
      step();
      if (gi) iAddr = $urandom;
      else begin dAddr = $urandom; dWdata = $urandom; dWe = ~dWe; end
      #1;
      chk("rnd_acc_busy", 32'(busy), 1);
      chk("rnd_acc_memAddr", memAddr, a);
      chk("rnd_acc_memRe", 32'(memRe), 32'(!we));
      chk("rnd_acc_memWe", 32'(memWe), 32'(we));
      chk("rnd_acc_memWdata", memWdata, we ? wd : 32'd0);
      chk("rnd_acc_done", {30'd0, dDone, iDone}, 0);
      if (we) ref_mem[a] = wd;
      step();
      if (!we) begin
        if (gi) exp_ird = ref_rd(a);
        else    exp_drd = ref_rd(a);
      end
      chk("rnd_resp_done", {30'd0, dDone, iDone}, gi ? 32'd1 : 32'd2);
      chk("rnd_resp_dRdata", dRdata, exp_drd);
      chk("rnd_resp_iRdata", iRdata, exp_ird);
      chk("rnd_resp_busy", 32'(busy), 1);
      chk_idle_mem("rnd_resp");
      if (gi) ip = 0;
      else    dp = 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: DATA_STREAK_MAX, 4, max consecutive contended data grants before instruction port is forced a grant (range 1..15).
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 dReq  in  1  data port request; held with dWe/dAddr/dWdata stable until dDone.
REQ-005 dWe  in  1  1 = write, 0 = read.
REQ-006 dAddr  in  32  data access address.
REQ-007 dWdata  in  32  write data.
REQ-008 dDone  out  1  one-cycle completion pulse for data access.
REQ-009 dRdata  out  32  data read result.
REQ-010 iReq  in  1  instruction fetch request; held with iAddr stable until iDone.
REQ-011 iAddr  in  32  fetch address.
REQ-012 iDone  out  1  one-cycle completion pulse for fetch.
REQ-013 iRdata  out  32  fetched instruction.
REQ-014 memAddr  out  32  shared memory address.
REQ-015 memWe  out  1  memory write enable.
REQ-016 memRe  out  1  memory read enable.
REQ-017 memWdata  out  32  memory write data.
REQ-018 memRdata  in  32  memory read data, valid the cycle after the cycle memRe=1 (synchronous read).
REQ-019 busy  out  1  1 whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; exactly one access in flight.
REQ-021 IDLE: no request -> stay IDLE; any request -> grant one port, latch its address/we/wdata and owner into registers, go ACCESS.
REQ-022 ACCESS (one cycle): memAddr = latched address; memRe = ~latchedWe; memWe = latchedWe; memWdata = latched wdata (0 on reads); go RESP.
REQ-023 RESP (one cycle): owner's done = 1; on read, owner's rdata = memRdata this cycle; go IDLE unconditionally.
REQ-024 Latency: request seen in IDLE at cycle N -> done pulse in cycle N+2; max throughput one access per 3 cycles.
REQ-025 memRe, memWe, memAddr, memWdata SHALL be 0 in IDLE and RESP.
REQ-026 dRdata/iRdata SHALL hold the last completed read value of their port until that port's next read completes; writes do not alter dRdata.
REQ-027 Arbitration, only one request: grant it.
REQ-028 Arbitration, both requests: grant data unless streak counter == DATA_STREAK_MAX, then grant instruction.
REQ-029 Streak counter (4-bit): +1 on each data grant made while iReq = 1, saturating at DATA_STREAK_MAX; cleared on any instruction grant; unchanged on uncontended data grants.
REQ-030 Requester SHALL deassert or change its request in the cycle after done; arbiter re-arbitrates in IDLE only, so a still-held request is treated as a new access.
REQ-031 Request dropped before done (protocol violation): transaction still completes and done still pulses.
REQ-032 Inputs sampled only at the IDLE grant edge; changes during ACCESS/RESP have no effect on the in-flight access.
REQ-033 dDone and iDone SHALL never be 1 in the same cycle.

Reset
REQ-034 On reset assertion, immediately: state IDLE, streak counter 0, latched registers 0, all outputs 0 (dRdata, iRdata included).
REQ-035 Reset during ACCESS: memWe drops asynchronously, write is not committed, no done pulse issued.
REQ-036 First grant possible at first rising edge after reset deasserts.

Verification
REQ-037 Fetch only: iReq=1, iAddr=0x10, mem[0x10]=0x00500093 -> memRe=1/memAddr=0x10 in cycle 1, iDone=1 with iRdata=0x00500093 in cycle 2.
REQ-038 Data write then read: dWe=1 dAddr=0x40 dWdata=0xDEADBEEF -> memWe=1 one cycle, dDone cycle 2; subsequent read of 0x40 -> dRdata=0xDEADBEEF, dRdata unchanged by the write.
REQ-039 Contention, DATA_STREAK_MAX=4: dReq and iReq held continuously -> grant order D,D,D,D,I,D,D,D,D,I; iDone never starved beyond 4 data grants.
REQ-040 Simultaneous first requests after reset -> data granted first, iDone follows 3 cycles after dDone.
REQ-041 Reset asserted in ACCESS of write to 0x80 -> memWe=0 immediately, mem[0x80] unchanged, no dDone, busy=0.
REQ-042 dReq dropped in ACCESS cycle -> dDone still pulses in RESP, FSM returns IDLE.
